mario_game_ctrl: RTL and testbench
==================================

// Module: mario_game_ctrl
// PURPOSE
//  Top-level sequencer for the Mario position register datapath.
//  Sequences the game through its phases: idle, level init, sprite draw, per-tick move/jump/fall, level advance, death and win.
//  Drives the datapath strobes and level selects: start, drStageN, lvlN, erM, jumping, falling.
//  Consumes the datapath status flags: ground, pipe, next, flag, dead.
// PARAMETERS
//  TICK_DIV     default 4   clk cycles per movement tick (>=4)
//  JUMP_HEIGHT  default 24  jumping steps per jump (>=1)
// PORTS
//  clk          in   1  system clock, all state on posedge
//  reset        in   1  asynchronous, active-high reset
//  go           in   1  start / restart button (level)
//  jump         in   1  jump button (level)
//  right, left  in   1  direction buttons (level)
//  ground       in   1  datapath: sprite standing on a surface
//  pipe         in   1  datapath: lvl1 pipe entry reached
//  next         in   1  datapath: lvl2 exit reached
//  flag         in   1  datapath: lvl3 flag reached
//  dead         in   1  datapath: sprite fell into a pit
//  start        out  1  one-cycle datapath re-init strobe
//  drStage1..3  out  1  one-cycle initial-position load strobe for the current level
//  lvl1..3      out  1  one-hot level select; all 0 when no level is active
//  erM          out  1  one-cycle horizontal step strobe
//  jumping      out  1  one-cycle upward step strobe
//  falling      out  1  one-cycle downward step strobe
//  game_over    out  1  high while in DEAD
//  win          out  1  high while in WIN
// BEHAVIOUR
//  Reset (async):
//   - state=IDLE, level=0, all outputs 0, tick counter 0, jump_cnt 0.
//   - Reset asserted mid-jump or mid-step drops all strobes in the same cycle.
//  Tick counter:
//   - Free-runs 0..TICK_DIV-1.
//   - tick=1 for the one cycle in which count==TICK_DIV-1.
//  lvlN = (level==N). Levels are always entered through INIT.
//  FSM states and transitions:
//   IDLE:   go=1 -> level=1, INIT.
//   INIT:   start=1 for 1 cycle -> DRAW.
//   DRAW:   drStage[level]=1 for 1 cycle -> COMMIT.
//   WAIT:   advances only on tick. First matching rule wins:
//     1. dead && level==1                        -> DEAD
//     2. (pipe&&lvl1)|(next&&lvl2)|(flag&&lvl3)  -> ADVANCE
//     3. jump_cnt!=0                 -> STEP, jumping=1, jump_cnt-=1
//     4. !ground                     -> STEP, falling=1
//     5. jump && ground              -> STEP, jumping=1, jump_cnt=JUMP_HEIGHT-1
//     6. right XOR left              -> STEP, erM=1
//     7. otherwise                   -> remain in WAIT
//   STEP:    exactly one strobe high for exactly 1 cycle -> COMMIT.
//   COMMIT:  all strobes 0 for 1 cycle (datapath latches position) -> WAIT.
//   ADVANCE: level 1->2, 2->3 -> INIT; level 3 -> WIN.
//   DEAD:    game_over=1; go=1 -> level=1, jump_cnt=0, INIT.
//   WIN:     win=1, lvl3 held; go=1 -> level=1, INIT.
//  Strobe rules:
//   - start, drStageN, erM, jumping, falling are mutually exclusive and registered.
//   - left and right both held means no horizontal step.
//   - A held jump does not re-trigger until jump_cnt==0 and ground==1.
//  Status latency:
//   - Datapath flags lag its registers by 1 cycle.
//   - COMMIT plus TICK_DIV>=4 guarantees flags are settled before the next tick.
//   - jump_cnt is cleared on INIT.
// TESTING
//  1. Reset, go=1 for 1 cycle -> next cycles: start pulse, then drStage1 pulse with lvl1=1; no step strobe before the first tick.
//  2. lvl1, ground=1, right held 12 ticks -> 12 erM pulses, each 1 cycle, spaced TICK_DIV cycles apart, jumping/falling stay 0.
//  3. ground=1, jump pulsed -> 24 consecutive tick jumping pulses; then ground=0 gives falling pulses until ground=1; a held jump gives no retrigger mid-air.
//  4. lvl1 pipe=1 at tick -> start, drStage2, lvl2=1; next=1 -> lvl3; flag=1 -> win=1, lvl3 held, no strobes.
//  5. lvl1 dead=1 at tick -> game_over=1, strobes 0; go=1 -> start, drStage1, lvl1=1, game_over=0.
//  6. Assert reset mid-jump (jumping high) -> all outputs 0 immediately, state IDLE; after release no strobe until go.

Source files
------------

// File: rtl/mario_game_ctrl_if.sv
// Control/status bundle between the Mario game sequencer and its datapath and buttons.
// The master side drives the buttons and status flags. The slave side is the sequencer.
interface mario_game_if;
    logic go;
    logic jump;
    logic right;
    logic left;
    logic ground;
    logic pipe;
    logic next;
    logic flag;
    logic dead;

    logic start;
    logic drStage1;
    logic drStage2;
    logic drStage3;
    logic lvl1;
    logic lvl2;
    logic lvl3;
    logic erM;
    logic jumping;
    logic falling;
    logic game_over;
    logic win;

    modport master (
        output go, jump, right, left, ground, pipe, next, flag, dead,
        input  start, drStage1, drStage2, drStage3, lvl1, lvl2, lvl3,
        input  erM, jumping, falling, game_over, win
    );

    modport slave (
        input  go, jump, right, left, ground, pipe, next, flag, dead,
        output start, drStage1, drStage2, drStage3, lvl1, lvl2, lvl3,
        output erM, jumping, falling, game_over, win
    );
endinterface

// File: rtl/mario_game_ctrl.sv
// Game phase sequencer for the Mario position datapath. It issues one strobe per movement tick
// and sequences the level changes, death and win.
module mario_game_ctrl #(
    parameter int TICK_DIV    = 4,
    parameter int JUMP_HEIGHT = 24
) (
    input  logic          clk,
    input  logic          reset,
    mario_game_if.slave   bus
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int JW = $clog2(JUMP_HEIGHT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_DRAW, S_WAIT, S_STEP, S_COMMIT, S_ADVANCE, S_DEAD, S_WIN
    } state_t;

    typedef enum logic [1:0] {
        STEP_MOVE, STEP_JUMP, STEP_FALL
    } step_t;

    state_t          r_state;
    state_t          w_state_next;
    step_t           r_step;
    step_t           w_step_next;
    logic [1:0]      r_level;
    logic [1:0]      w_level_next;
    logic [JW-1:0]   r_jump_cnt;
    logic [JW-1:0]   w_jump_cnt_next;
    logic [TW-1:0]   r_tick_cnt;
    logic            w_tick;
    logic            w_advance;

    assign w_tick    = (r_tick_cnt == TW'(TICK_DIV - 1));
    assign w_advance = (bus.pipe && r_level == 2'd1) ||
                       (bus.next && r_level == 2'd2) ||
                       (bus.flag && r_level == 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_step     <= STEP_MOVE;
            r_level    <= 2'd0;
            r_jump_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_step     <= w_step_next;
            r_level    <= w_level_next;
            r_jump_cnt <= w_jump_cnt_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_step_next     = r_step;
        w_level_next    = r_level;
        w_jump_cnt_next = r_jump_cnt;
        case (r_state)
            S_IDLE: begin
                if (bus.go) begin
                    w_level_next = 2'd1;
                    w_state_next = S_INIT;
                end
            end
            S_INIT: begin
                w_jump_cnt_next = '0;
                w_state_next    = S_DRAW;
            end
            S_DRAW:   w_state_next = S_COMMIT;
            S_STEP:   w_state_next = S_COMMIT;
            S_COMMIT: w_state_next = S_WAIT;
            S_WAIT: begin
                // Decisions are made only on a tick. The first matching rule wins.
                if (w_tick) begin
                    if (bus.dead && r_level == 2'd1) begin
                        w_state_next = S_DEAD;
                    end else if (w_advance) begin
                        w_state_next = S_ADVANCE;
                    end else if (r_jump_cnt != '0) begin
                        w_state_next    = S_STEP;
                        w_step_next     = STEP_JUMP;
                        w_jump_cnt_next = r_jump_cnt - 1'b1;
                    end else if (!bus.ground) begin
                        w_state_next = S_STEP;
                        w_step_next  = STEP_FALL;
                    end else if (bus.jump) begin
                        w_state_next    = S_STEP;
                        w_step_next     = STEP_JUMP;
                        w_jump_cnt_next = JW'(JUMP_HEIGHT - 1);
                    end else if (bus.right ^ bus.left) begin
                        w_state_next = S_STEP;
                        w_step_next  = STEP_MOVE;
                    end
                end
            end
            S_ADVANCE: begin
                if (r_level == 2'd3) begin
                    w_state_next = S_WIN;
                end else begin
                    w_level_next = r_level + 2'd1;
                    w_state_next = S_INIT;
                end
            end
            S_DEAD: begin
                if (bus.go) begin
                    w_level_next    = 2'd1;
                    w_jump_cnt_next = '0;
                    w_state_next    = S_INIT;
                end
            end
            S_WIN: begin
                if (bus.go) begin
                    w_level_next = 2'd1;
                    w_state_next = S_INIT;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Every output is decoded from registered state. This keeps the strobes glitch-free and
    // mutually exclusive.
    always_comb begin
        bus.start     = (r_state == S_INIT);
        bus.drStage1  = (r_state == S_DRAW) && (r_level == 2'd1);
        bus.drStage2  = (r_state == S_DRAW) && (r_level == 2'd2);
        bus.drStage3  = (r_state == S_DRAW) && (r_level == 2'd3);
        bus.erM       = (r_state == S_STEP) && (r_step == STEP_MOVE);
        bus.jumping   = (r_state == S_STEP) && (r_step == STEP_JUMP);
        bus.falling   = (r_state == S_STEP) && (r_step == STEP_FALL);
        bus.lvl1      = (r_level == 2'd1);
        bus.lvl2      = (r_level == 2'd2);
        bus.lvl3      = (r_level == 2'd3);
        bus.game_over = (r_state == S_DEAD);
        bus.win       = (r_state == S_WIN);
    end
endmodule

// File: tb/tb_mario_game_ctrl.sv
// Scoreboard bench for mario_game_ctrl. The stimulus queues the expected strobe vectors.
// A negedge monitor pops one entry per observed strobe and checks its value and its spacing.
module tb_mario_game_ctrl;
    localparam int TICK_DIV    = 4;
    localparam int JUMP_HEIGHT = 24;

    localparam logic [11:0] B_START = 12'h800;
    localparam logic [11:0] B_DR1   = 12'h400;
    localparam logic [11:0] B_DR2   = 12'h200;
    localparam logic [11:0] B_DR3   = 12'h100;
    localparam logic [11:0] B_L1    = 12'h080;
    localparam logic [11:0] B_L2    = 12'h040;
    localparam logic [11:0] B_L3    = 12'h020;
    localparam logic [11:0] B_ERM   = 12'h010;
    localparam logic [11:0] B_JMP   = 12'h008;
    localparam logic [11:0] B_FALL  = 12'h004;
    localparam logic [11:0] B_OVER  = 12'h002;
    localparam logic [11:0] B_WIN   = 12'h001;

    typedef struct {
        string       name;
        logic [11:0] vec;
        int          gap;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mario_game_if gif();

    mario_game_ctrl #(.TICK_DIV(TICK_DIV), .JUMP_HEIGHT(JUMP_HEIGHT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (gif.slave)
    );

    wire [11:0] obs = {gif.start, gif.drStage1, gif.drStage2, gif.drStage3,
                       gif.lvl1, gif.lvl2, gif.lvl3, gif.erM, gif.jumping,
                       gif.falling, gif.game_over, gif.win};
    wire strobe_any = gif.start | gif.drStage1 | gif.drStage2 | gif.drStage3 |
                      gif.erM | gif.jumping | gif.falling;

    exp_t sb_q[$];
    exp_t mon_e;
    int total = 0;
    int bad = 0;
    int cycle = 0;
    int last_cycle = 0;

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (!reset && strobe_any) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe got=%h want=none cycle=%0d", obs, cycle);
            end else begin
                mon_e = sb_q.pop_front();
                if (obs !== mon_e.vec || (mon_e.gap != 0 && (cycle - last_cycle) != mon_e.gap)) begin
                    bad++;
                    $display("FAIL %s got=%h want=%h gap=%0d want_gap=%0d",
                             mon_e.name, obs, mon_e.vec, cycle - last_cycle, mon_e.gap);
                end else begin
                    $display("txn %s vec=%h gap=%0d", mon_e.name, obs, cycle - last_cycle);
                end
            end
            last_cycle = cycle;
        end
    end

    task automatic expect_strobe(input string nm, input logic [11:0] v, input int gap);
        exp_t e;
        e.name = nm;
        e.vec  = v;
        e.gap  = gap;
        sb_q.push_back(e);
    endtask

    task automatic check_vec(input string nm, input logic [11:0] want);
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, obs, want);
        end else begin
            $display("txn %s vec=%h", nm, obs);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic go_pulse();
        gif.go = 1'b1;
        cycles(1);
        gif.go = 1'b0;
    endtask

    initial begin
        bit found;
        gif.go = 0; gif.jump = 0; gif.right = 0; gif.left = 0; gif.ground = 1;
        gif.pipe = 0; gif.next = 0; gif.flag = 0; gif.dead = 0;

        cycles(3);
        @(negedge clk);
        check_vec("reset_state", 12'h000);
        cycles(1);
        reset = 1'b0;
        cycles(6);

        // Start the game from IDLE.
        expect_strobe("start_l1", B_START | B_L1, 0);
        expect_strobe("draw_l1", B_DR1 | B_L1, 1);
        go_pulse();
        cycles(10);

        // Hold right for 12 ticks, then hold both directions, then left alone.
        for (int i = 0; i < 12; i++) expect_strobe("move_right", B_ERM | B_L1, (i == 0) ? 0 : TICK_DIV);
        gif.right = 1'b1;
        cycles(12 * TICK_DIV);
        gif.left = 1'b1;
        cycles(16);
        gif.right = 1'b0;
        gif.left = 1'b0;
        cycles(4);
        expect_strobe("move_left", B_ERM | B_L1, 0);
        expect_strobe("move_left", B_ERM | B_L1, TICK_DIV);
        gif.left = 1'b1;
        cycles(2 * TICK_DIV);
        gif.left = 1'b0;
        cycles(8);

        // Full jump, then fall with jump still held.
        for (int i = 0; i < JUMP_HEIGHT; i++) expect_strobe("jump_up", B_JMP | B_L1, (i == 0) ? 0 : TICK_DIV);
        for (int i = 0; i < 5; i++) expect_strobe("fall_down", B_FALL | B_L1, TICK_DIV);
        gif.jump = 1'b1;
        cycles(JUMP_HEIGHT * TICK_DIV);
        gif.ground = 1'b0;
        cycles(5 * TICK_DIV);
        gif.ground = 1'b1;
        gif.jump = 1'b0;
        cycles(12);

        // Advance through the levels to the win state.
        expect_strobe("start_l2", B_START | B_L2, 0);
        expect_strobe("draw_l2", B_DR2 | B_L2, 1);
        gif.pipe = 1'b1;
        cycles(TICK_DIV);
        gif.pipe = 1'b0;
        cycles(10);
        expect_strobe("start_l3", B_START | B_L3, 0);
        expect_strobe("draw_l3", B_DR3 | B_L3, 1);
        gif.next = 1'b1;
        cycles(TICK_DIV);
        gif.next = 1'b0;
        cycles(10);
        gif.flag = 1'b1;
        cycles(TICK_DIV);
        gif.flag = 1'b0;
        cycles(2);
        @(negedge clk);
        check_vec("win_state", B_WIN | B_L3);
        cycles(1);
        gif.right = 1'b1;
        cycles(8);
        gif.right = 1'b0;
        @(negedge clk);
        check_vec("win_hold", B_WIN | B_L3);
        cycles(1);
        expect_strobe("restart_l1", B_START | B_L1, 0);
        expect_strobe("redraw_l1", B_DR1 | B_L1, 1);
        go_pulse();
        cycles(10);

        // Death in level 1, then a restart.
        gif.dead = 1'b1;
        cycles(TICK_DIV);
        gif.dead = 1'b0;
        cycles(2);
        @(negedge clk);
        check_vec("dead_state", B_OVER | B_L1);
        cycles(1);
        gif.right = 1'b1;
        cycles(8);
        gif.right = 1'b0;
        expect_strobe("revive_start", B_START | B_L1, 0);
        expect_strobe("revive_draw", B_DR1 | B_L1, 1);
        go_pulse();
        cycles(6);
        @(negedge clk);
        check_vec("after_revive", B_L1);
        cycles(1);

        // Reset asserted while jumping is high.
        expect_strobe("jump_before_reset", B_JMP | B_L1, 0);
        gif.jump = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (gif.jumping) begin
                found = 1'b1;
                break;
            end
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL jump_seen got=0 want=1");
        end
        #1 reset = 1'b1;
        #1 check_vec("reset_midjump", 12'h000);
        cycles(3);
        reset = 1'b0;
        gif.right = 1'b1;
        cycles(16);
        @(negedge clk);
        check_vec("idle_after_reset", 12'h000);
        gif.jump = 1'b0;
        gif.right = 1'b0;
        cycles(4);

        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_expected got=%0d want=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
